// File: rtl/m_unit_arbiter.sv
// rtl/m_unit_arbiter.sv - round-robin arbiter sharing one PCPI-style M-extension unit among NUM_REQ requesters
// Optional issue timeout enabled by defining M_ARB_TIMEOUT_EN.
module m_unit_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_instruction,
    input  logic [32*NUM_REQ-1:0] req_rs1,
    input  logic [32*NUM_REQ-1:0] req_rs2,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  req_wr,
    output logic [31:0]           req_rd,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic                  m_valid,
    output logic [31:0]           m_instruction,
    output logic [31:0]           m_rs1,
    output logic [31:0]           m_rs2,
    input  logic                  m_wr,
    input  logic [31:0]           m_rd,
    input  logic                  m_busy,
    input  logic                  m_ready,
    output logic                  timeout_err
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] next_grant;
    logic          found;
    int            idx;

    // Search starts just after the last served requester, so it is the last candidate.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                next_grant = GW'(idx);
            end
        end
    end

    always_comb begin
        req_busy = '0;
        if (state != IDLE) begin
            req_busy[grant] = 1'b1;
        end
    end

`ifdef M_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcount;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= LAST_INIT;
            m_valid       <= 1'b0;
            m_instruction <= '0;
            m_rs1         <= '0;
            m_rs2         <= '0;
            req_ready     <= '0;
            req_wr        <= 1'b0;
            req_rd        <= '0;
`ifdef M_ARB_TIMEOUT_EN
            tcount        <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant         <= next_grant;
                        m_instruction <= req_instruction[32*next_grant +: 32];
                        m_rs1         <= req_rs1[32*next_grant +: 32];
                        m_rs2         <= req_rs2[32*next_grant +: 32];
                        m_valid       <= 1'b1;
                        state         <= ISSUE;
`ifdef M_ARB_TIMEOUT_EN
                        tcount        <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        req_rd    <= m_rd;
                        req_wr    <= m_wr;
                        m_valid   <= 1'b0;
                        req_ready <= NUM_REQ'(1) << grant;
                        state     <= RESP;
                    end
`ifdef M_ARB_TIMEOUT_EN
                    else if (tcount == TW'(TIMEOUT - 1)) begin
                        req_rd      <= '0;
                        req_wr      <= 1'b0;
                        m_valid     <= 1'b0;
                        req_ready   <= NUM_REQ'(1) << grant;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
`endif
                end
                RESP: begin
                    req_ready  <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
`ifdef M_ARB_TIMEOUT_EN
                    timeout_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // m_busy is informational only.
    logic unused_inputs;
    assign unused_inputs = m_busy ^ (TIMEOUT == 0);
endmodule

// File: tb/tb_m_unit_arbiter.sv
// tb/tb_m_unit_arbiter.sv - self-checking bench for m_unit_arbiter with a behavioural M-unit stub
module tb_m_unit_arbiter;
    localparam int N = 2;
    localparam logic [31:0] MUL  = 32'h02B50533;
    localparam logic [31:0] DIVU = 32'h02B55533;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_instruction = '0;
    logic [32*N-1:0] req_rs1 = '0;
    logic [32*N-1:0] req_rs2 = '0;
    logic [N-1:0]    req_ready;
    logic            req_wr;
    logic [31:0]     req_rd;
    logic [N-1:0]    req_busy;
    logic            m_valid;
    logic [31:0]     m_instruction;
    logic [31:0]     m_rs1;
    logic [31:0]     m_rs2;
    logic            m_wr = 1'b0;
    logic [31:0]     m_rd = '0;
    logic            m_busy;
    logic            m_ready = 1'b0;
    logic            timeout_err;

    m_unit_arbiter #(.NUM_REQ(N), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_instruction(req_instruction),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_ready(req_ready), .req_wr(req_wr), .req_rd(req_rd), .req_busy(req_busy),
        .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int   stub_lat = 0;
    logic stub_hang = 1'b0;
    logic stub_wr = 1'b1;
    int   stub_cnt = 0;

    function automatic logic [31:0] unit_calc(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        if (ins[14:12] == 3'b101) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        return a * b;
    endfunction

    assign m_busy = m_valid & ~m_ready;

    always @(posedge clk) begin
        if (reset || !m_valid) begin
            stub_cnt <= 0;
            m_ready  <= 1'b0;
        end else if (m_ready) begin
            m_ready <= 1'b0;
        end else if (!stub_hang && stub_cnt == stub_lat) begin
            m_ready <= 1'b1;
            m_rd    <= unit_calc(m_instruction, m_rs1, m_rs2);
            m_wr    <= stub_wr;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    int resp_valid_bad = 0;
    always @(negedge clk) begin
        if (!reset && (|req_ready) && m_valid) resp_valid_bad <= resp_valid_bad + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        req_instruction[32*i +: 32] = ins;
        req_rs1[32*i +: 32]         = a;
        req_rs2[32*i +: 32]         = b;
    endtask

    task automatic wait_ready(input string name, input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (req_ready == '0 && cycles < budget);
        if (req_ready == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: no req_ready within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] i0, a0, b0, i1, a1, b1;
        int          lat;
        logic        wr;
        int          n;
        logic [1:0]  first;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          cyc;
        int          bad;
        int          pulses;
        logic [1:0]  exp_ready;
        logic [31:0] exp_rd;

        // Rows run back to back after a reset, so each winner depends on the previous row.
        vecs[0] = '{2'b11, DIVU, 32'd100, 32'd7, MUL, 32'd6, 32'd7, 2, 1'b1, 2, 2'b01, 32'd14, 32'd42};
        vecs[1] = '{2'b01, MUL, 32'd6, 32'd7, MUL, 32'd0, 32'd0, 0, 1'b1, 1, 2'b01, 32'd42, 32'd0};
        vecs[2] = '{2'b11, DIVU, 32'd100, 32'd7, MUL, 32'd6, 32'd7, 1, 1'b1, 2, 2'b10, 32'd42, 32'd14};
        vecs[3] = '{2'b10, MUL, 32'd0, 32'd0, MUL, 32'hFFFF_FFFF, 32'd2, 3, 1'b0, 1, 2'b10, 32'hFFFF_FFFE, 32'd0};
        vecs[4] = '{2'b11, MUL, 32'h0001_0000, 32'h0001_0000, DIVU, 32'd7, 32'd0, 0, 1'b1, 2, 2'b01, 32'd0, 32'hFFFF_FFFF};

        tick();
        tick();
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_instruction", m_instruction, 32'd0);
        chk("rst_m_rs1", m_rs1, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_req_busy", 32'(req_busy), 32'd0);
        chk("rst_req_rd", req_rd, 32'd0);
        chk("rst_req_wr", {31'b0, req_wr}, 32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        reset = 1'b0;

        // Single MUL: issue one cycle after request, ready two cycles later with a zero-latency unit.
        set_req(0, MUL, 32'd6, 32'd7);
        req_valid = 2'b01;
        tick();
        chk("mul_m_valid", {31'b0, m_valid}, 32'd1);
        chk("mul_m_instruction", m_instruction, MUL);
        chk("mul_m_rs1", m_rs1, 32'd6);
        chk("mul_m_rs2", m_rs2, 32'd7);
        chk("mul_busy_issue", 32'(req_busy), 32'd1);
        wait_ready("mul_wait", 10, cyc);
        chk("mul_latency", cyc, 32'd2);
        chk("mul_ready", 32'(req_ready), 32'd1);
        chk("mul_rd", req_rd, 32'd42);
        chk("mul_wr", {31'b0, req_wr}, 32'd1);
        chk("mul_busy_resp", 32'(req_busy), 32'd1);
        req_valid = '0;
        tick();
        chk("mul_ready_pulse", 32'(req_ready), 32'd0);
        chk("mul_busy_after", 32'(req_busy), 32'd0);

        do_reset();
        for (int r = 0; r < 5; r++) begin
            stub_lat = vecs[r].lat;
            stub_wr  = vecs[r].wr;
            set_req(0, vecs[r].i0, vecs[r].a0, vecs[r].b0);
            set_req(1, vecs[r].i1, vecs[r].a1, vecs[r].b1);
            req_valid = vecs[r].mask;
            for (int s = 0; s < vecs[r].n; s++) begin
                wait_ready($sformatf("row%0d_wait%0d", r, s), 40, cyc);
                exp_ready = (s == 0) ? vecs[r].first : (vecs[r].mask & ~vecs[r].first);
                exp_rd    = (s == 0) ? vecs[r].rd0 : vecs[r].rd1;
                chk($sformatf("row%0d_ready%0d", r, s), 32'(req_ready), 32'(exp_ready));
                chk($sformatf("row%0d_rd%0d", r, s), req_rd, exp_rd);
                chk($sformatf("row%0d_wr%0d", r, s), {31'b0, req_wr}, {31'b0, vecs[r].wr});
                req_valid = req_valid & ~req_ready;
            end
            tick();
            tick();
        end
        stub_lat = 0;
        stub_wr  = 1'b1;

        // Fairness: both held continuously, grants must alternate from requester 0.
        do_reset();
        set_req(0, MUL, 32'd6, 32'd7);
        set_req(1, MUL, 32'd6, 32'd7);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_ready($sformatf("fair_wait%0d", k), 20, cyc);
            chk($sformatf("fair_grant%0d", k), 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k == 5) req_valid = '0;
        end
        tick();

        // Slow unit: 20 cycles of held issue, then one pulse.
        stub_lat = 19;
        set_req(0, DIVU, 32'd100, 32'd7);
        req_valid = 2'b01;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_valid !== 1'b1 || m_instruction !== DIVU || m_rs1 !== 32'd100 ||
                m_rs2 !== 32'd7 || req_ready !== '0) bad++;
        end
        chk("slow_hold", bad, 32'd0);
        wait_ready("slow_wait", 6, cyc);
        chk("slow_latency", cyc, 32'd2);
        chk("slow_ready", 32'(req_ready), 32'd1);
        chk("slow_rd", req_rd, 32'd14);
        req_valid = '0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (req_ready != '0) pulses++;
        end
        chk("slow_single_pulse", pulses, 32'd0);
        stub_lat = 0;

        // Reset three cycles into ISSUE; afterwards requester 0 wins again.
        do_reset();
        set_req(0, MUL, 32'd6, 32'd7);
        req_valid = 2'b01;
        wait_ready("rstmid_pre", 10, cyc);
        req_valid = '0;
        tick();
        stub_hang = 1'b1;
        set_req(1, MUL, 32'd3, 32'd5);
        req_valid = 2'b10;
        tick();
        chk("rstmid_busy_issue", 32'(req_busy), 32'd2);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rstmid_busy", 32'(req_busy), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        stub_hang = 1'b0;
        req_valid = 2'b11;
        wait_ready("rstmid_first", 10, cyc);
        chk("rstmid_first_grant", 32'(req_ready), 32'd1);
        req_valid = req_valid & ~req_ready;
        wait_ready("rstmid_second", 10, cyc);
        chk("rstmid_second_grant", 32'(req_ready), 32'd2);
        chk("rstmid_second_rd", req_rd, 32'd15);
        req_valid = '0;
        tick();

        // Unit never answers.
        stub_hang = 1'b1;
        set_req(0, MUL, 32'd9, 32'd9);
        req_valid = 2'b01;
`ifdef M_ARB_TIMEOUT_EN
        wait_ready("timeout_wait", 20, cyc);
        chk("timeout_latency", cyc, 32'd9);
        chk("timeout_ready", 32'(req_ready), 32'd1);
        chk("timeout_err", {31'b0, timeout_err}, 32'd1);
        chk("timeout_rd", req_rd, 32'd0);
        chk("timeout_wr", {31'b0, req_wr}, 32'd0);
        req_valid = '0;
        tick();
        chk("timeout_err_pulse", {31'b0, timeout_err}, 32'd0);
`else
        pulses = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (req_ready != '0) pulses++;
            if (timeout_err !== 1'b0) bad++;
        end
        chk("hang_no_ready", pulses, 32'd0);
        chk("hang_no_timeout_err", bad, 32'd0);
        chk("hang_m_valid_held", {31'b0, m_valid}, 32'd1);
        do_reset();
`endif
        stub_hang = 1'b0;
        tick();

        chk("m_valid_in_resp", resp_valid_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
